// File: rtl/mealy_seq_pkg.sv
// mealy_seq_pkg
// Shared constants and types for the Mealy stream sequencer:
//   - detector state encodings ST_A..ST_E (3-bit, Gray-like)
//   - controller state enum ctrl_state_t (IDLE, SHIFT, DONE)
//   - WORD_W_DEF, the default serialised word width
package mealy_seq_pkg;

   localparam int WORD_W_DEF = 8;

   localparam logic [2:0] ST_A = 3'b000;
   localparam logic [2:0] ST_B = 3'b001;
   localparam logic [2:0] ST_C = 3'b011;
   localparam logic [2:0] ST_D = 3'b010;
   localparam logic [2:0] ST_E = 3'b100;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } ctrl_state_t;

endpackage

// File: rtl/mealy_stream_sequencer_det_core.sv
// mealy_det_core
// Five-state Mealy sequence detector: state register, next-state logic and
// the combinational output z.
// Ports:
//   clk    in   system clock
//   rst_n  in   synchronous active-low reset (state -> A)
//   clr    in   synchronous clear to A, has priority over step
//   step   in   advance the detector by one bit
//   x      in   serial input bit
//   state  out  current detector state encoding
//   z      out  Mealy output, combinational from state and x
//
// state | meaning
// A 000 | start / pattern restart
// B 001 | seen 0
// C 011 | seen 00 or 11; z when x=1
// D 010 | seen 1
// E 100 | seen 01 or 10; z when x=0
module mealy_det_core
   import mealy_seq_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       step,
   input  logic       x,
   output logic [2:0] state,
   output logic       z
);

   logic [2:0] state_next;

   always_comb begin
      state_next = ST_A;
      case (state)
         ST_A:    state_next = x ? ST_D : ST_B;
         ST_B:    state_next = x ? ST_E : ST_C;
         ST_D:    state_next = x ? ST_C : ST_E;
         ST_C:    state_next = ST_A;
         ST_E:    state_next = ST_A;
         default: state_next = ST_A;
      endcase
   end

   assign z = ((state == ST_E) & ~x) | ((state == ST_C) & x);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_A;
      end else if (clr) begin
         state <= ST_A;
      end else if (step) begin
         state <= state_next;
      end
   end

endmodule

// File: rtl/mealy_stream_sequencer.sv
// mealy_stream_sequencer
// Shares one Mealy detector between two word requesters. Round-robin grant,
// LSB-first serialisation one bit per clock, saturating count of detector
// pulses, one-cycle result strobe with the owning requester ID.
// Optional build macro MEALY_CARRY_EN: detector state carries across words
// instead of being cleared to A on each accept.
// Ports:
//   clk                  in   system clock
//   rst_n                in   synchronous active-low reset
//   req0_valid/req0_data in   requester 0 word offer
//   req0_ready           out  requester 0 word accepted this cycle
//   req1_valid/req1_data in   requester 1 word offer
//   req1_ready           out  requester 1 word accepted this cycle
//   res_valid            out  one-cycle result strobe (DONE)
//   res_id               out  requester that owned the finished word
//   res_count            out  detector pulses over the word
//   busy                 out  high in SHIFT and DONE
//   det_state            out  current detector state encoding
//
// state | meaning
// IDLE  | waiting for a valid word; readies reflect the grant
// SHIFT | feeding WORD_W bits into the detector
// DONE  | result strobe for one cycle
module mealy_stream_sequencer
   import mealy_seq_pkg::*;
#(
   parameter  int WORD_W = WORD_W_DEF,
   localparam int CNT_W  = $clog2(WORD_W + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   input  logic [WORD_W-1:0] req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [WORD_W-1:0] req1_data,
   output logic              req1_ready,
   output logic              res_valid,
   output logic              res_id,
   output logic [CNT_W-1:0]  res_count,
   output logic              busy,
   output logic [2:0]        det_state
);

   localparam int IDX_W = $clog2(WORD_W);

   ctrl_state_t       state;
   ctrl_state_t       state_next;
   logic              last_grant;
   logic [WORD_W-1:0] shreg;
   logic [IDX_W-1:0]  bit_idx;
   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  count_inc;
   logic              id_q;

   logic              grant0;
   logic              grant1;
   logic              accept;
   logic              step;
   logic              last_bit;
   logic              det_clr;
   logic              z;

   // Tie goes to whoever did not win last; last_grant resets to 1 so req0
   // wins the first tie.
   assign grant0   = req0_valid & (~req1_valid | last_grant);
   assign grant1   = req1_valid & (~req0_valid | ~last_grant);
   assign accept   = (state == IDLE) & (grant0 | grant1);

   assign req0_ready = (state == IDLE) & grant0;
   assign req1_ready = (state == IDLE) & grant1;

   assign step     = (state == SHIFT);
   assign last_bit = (bit_idx == IDX_W'(WORD_W - 1));
   assign res_valid = (state == DONE);
   assign busy      = (state == SHIFT) | (state == DONE);

   // Saturating increment; the ceiling is unreachable for legal WORD_W but
   // keeps the count from wrapping if the width is ever narrowed.
   assign count_inc = (z && (count != '1)) ? count + 1'b1 : count;

`ifdef MEALY_CARRY_EN
   assign det_clr = 1'b0;
`else
   assign det_clr = accept;
`endif

   mealy_det_core u_det (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (det_clr),
      .step  (step),
      .x     (shreg[0]),
      .state (det_state),
      .z     (z)
   );

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = SHIFT;
         SHIFT:   if (last_bit) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         shreg      <= '0;
         bit_idx    <= '0;
         count      <= '0;
         id_q       <= 1'b0;
         res_id     <= 1'b0;
         res_count  <= '0;
      end else begin
         state <= state_next;
         if (accept) begin
            shreg      <= grant1 ? req1_data : req0_data;
            id_q       <= grant1;
            last_grant <= grant1;
            count      <= '0;
            bit_idx    <= '0;
         end else if (step) begin
            shreg   <= shreg >> 1;
            bit_idx <= bit_idx + 1'b1;
            count   <= count_inc;
            // Result registers load on the edge into DONE and hold until the
            // next word finishes.
            if (last_bit) begin
               res_count <= count_inc;
               res_id    <= id_q;
            end
         end
      end
   end

endmodule

// File: tb/tb_mealy_stream_sequencer.sv
// tb_mealy_stream_sequencer
// Self-checking bench for mealy_stream_sequencer (WORD_W = 8). Expected
// results are pushed to a scoreboard at accept and popped on res_valid.
// Honours MEALY_CARRY_EN in its detector model.
module tb_mealy_stream_sequencer;

   localparam int W  = 8;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req0_valid = 1'b0;
   logic [W-1:0]  req0_data = '0;
   logic          req0_ready;
   logic          req1_valid = 1'b0;
   logic [W-1:0]  req1_data = '0;
   logic          req1_ready;
   logic          res_valid;
   logic          res_id;
   logic [CW-1:0] res_count;
   logic          busy;
   logic [2:0]    det_state;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   typedef struct {
      logic id;
      int   cnt;
      int   due;
   } exp_t;

   exp_t       sb[$];
   logic [2:0] carry_st = 3'b000;

   mealy_stream_sequencer #(.WORD_W(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_data  (req0_data),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_data  (req1_data),
      .req1_ready (req1_ready),
      .res_valid  (res_valid),
      .res_id     (res_id),
      .res_count  (res_count),
      .busy       (busy),
      .det_state  (det_state)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Detector reference: A=000 B=001 C=011 D=010 E=100
   function automatic logic [2:0] det_next(input logic [2:0] s, input logic x);
      case (s)
         3'b000:  return x ? 3'b010 : 3'b001;
         3'b001:  return x ? 3'b100 : 3'b011;
         3'b010:  return x ? 3'b011 : 3'b100;
         default: return 3'b000;
      endcase
   endfunction

   function automatic int word_count(input logic [2:0] s0, input logic [W-1:0] w,
                                     output logic [2:0] s_end);
      logic [2:0] s = s0;
      int c = 0;
      for (int b = 0; b < W; b++) begin
         if ((s == 3'b100 && !w[b]) || (s == 3'b011 && w[b])) c++;
         s = det_next(s, w[b]);
      end
      s_end = s;
      return c;
   endfunction

   task automatic push_word(input logic id, input logic [W-1:0] d, output logic [2:0] st0);
      logic [2:0] s_end;
      exp_t e;
`ifdef MEALY_CARRY_EN
      st0 = carry_st;
`else
      st0 = 3'b000;
`endif
      e.id  = id;
      e.cnt = word_count(st0, d, s_end);
      e.due = cyc + W + 1;
      carry_st = s_end;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin
      if (rst_n && res_valid) begin
         if (sb.size() == 0) begin
            chk("unexpected_res", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("res_id", res_id, e.id);
            chk("res_count", res_count, e.cnt);
            chk("res_latency", cyc, e.due);
         end
      end
   end

   task automatic send(input logic id, input logic [W-1:0] d, input bit walk);
      logic [2:0] st;
      bit got = 0;
      @(posedge clk); #1;
      if (id) begin req1_valid = 1'b1; req1_data = d; end
      else    begin req0_valid = 1'b1; req0_data = d; end
      for (int i = 0; i < 30 && !got; i++) begin
         @(negedge clk);
         if (id ? req1_ready : req0_ready) begin
            got = 1;
            chk("other_ready", id ? req0_ready : req1_ready, 0);
            push_word(id, d, st);
         end
      end
      if (!got) chk("ready_timeout", 0, 1);
      @(posedge clk); #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      if (got && walk) begin
         for (int b = 0; b < W; b++) begin
            @(negedge clk);
            chk("busy", busy, 1);
            chk("det_state", det_state, st);
            chk("ready_in_shift", req0_ready | req1_ready, 0);
            st = det_next(st, d[b]);
         end
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
      @(negedge clk);
      chk("idle_busy", busy, 0);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   prev;
      int   n;
      logic exp_id;
      logic [2:0] st_unused;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_id", res_id, 0);
      chk("rst_res_count", res_count, 0);
      chk("rst_busy", busy, 0);
      chk("rst_det_state", det_state, 3'b000);
      chk("rst_ready0", req0_ready, 0);
      chk("rst_ready1", req1_ready, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      send(1'b0, 8'h00, 1); drain();
      send(1'b1, 8'hFF, 1); drain();
      send(1'b0, 8'h02, 1); drain();
      send(1'b0, 8'h01, 1); drain();
      send(1'b0, 8'h01, 1); drain();
      send(1'b0, 8'h01, 1); drain();
      send(1'b0, 8'h00, 1); drain();
      send(1'b1, 8'hB6, 1); drain();

      // Abort a word with reset at T+4; previous result was id 1.
      send(1'b1, 8'hFF, 0); drain();
      send(1'b1, 8'h55, 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk); #1;
      sb.delete();
      carry_st = 3'b000;
      @(negedge clk);
      chk("abort_res_valid", res_valid, 0);
      chk("abort_res_id", res_id, 0);
      chk("abort_res_count", res_count, 0);
      chk("abort_busy", busy, 0);
      chk("abort_det_state", det_state, 3'b000);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (12) @(posedge clk);

      // Both requesters hold valid: grants alternate starting with req0.
      #1;
      req0_valid = 1'b1; req0_data = 8'hFF;
      req1_valid = 1'b1; req1_data = 8'h02;
      exp_id = 1'b0;
      prev = -1;
      n = 0;
      for (int i = 0; i < 80 && n < 4; i++) begin
         @(negedge clk);
         if (req0_ready || req1_ready) begin
            chk("grant_id", req1_ready, exp_id);
            chk("both_ready", req0_ready & req1_ready, 0);
            if (prev >= 0) chk("accept_gap", cyc - prev, W + 2);
            prev = cyc;
            push_word(req1_ready, req1_ready ? req1_data : req0_data, st_unused);
            exp_id = ~exp_id;
            n++;
         end
      end
      if (n < 4) chk("alt_timeout", n, 4);
      @(posedge clk); #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
